// File: rtl/blake_pkg.sv
// Shared constants, state encoding and helpers for the BLAKE-512 round controller.
package blake_pkg;

    localparam int unsigned ROUNDS   = 16;
    localparam int unsigned STEPS    = 4;
    localparam int unsigned T_W      = 128;
    localparam int unsigned BLK_BITS = 1024;
    localparam int unsigned BITS_W   = 11;

    localparam int unsigned ROUND_W  = $clog2(ROUNDS);
    localparam int unsigned STEP_W   = $clog2(STEPS);

    // BLAKE-512 cycles through 10 sigma permutations (round mod 10).
    localparam int unsigned SIGMA_N     = 10;
    localparam int unsigned SIGMA_SEL_W = $clog2(SIGMA_N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // A block never carries more than BLK_BITS message bits.
    function automatic logic [BITS_W-1:0] sat_bits(input logic [BITS_W-1:0] bits);
        return (bits > BITS_W'(BLK_BITS)) ? BITS_W'(BLK_BITS) : bits;
    endfunction

endpackage

// File: rtl/blake_round_cnt.sv
// Step/round counter for one compression: steps wrap into rounds, tc marks the final step.
module blake_round_cnt
    import blake_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [ROUND_W-1:0] round_o,
    output logic [STEP_W-1:0]  step_o,
    output logic               tc_o
);

    logic [ROUND_W-1:0] round_q, round_d;
    logic [STEP_W-1:0]  step_q,  step_d;
    logic               step_wrap;

    always_comb begin
        step_wrap = (step_q == STEP_W'(STEPS - 1));
        tc_o      = step_wrap && (round_q == ROUND_W'(ROUNDS - 1));
        round_d   = round_q;
        step_d    = step_q;
        if (clr_i) begin
            round_d = '0;
            step_d  = '0;
        end else if (en_i) begin
            step_d = step_wrap ? '0 : step_q + STEP_W'(1);
            if (step_wrap) begin
                round_d = tc_o ? '0 : round_q + ROUND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
            step_q  <= '0;
        end else begin
            round_q <= round_d;
            step_q  <= step_d;
        end
    end

    assign round_o = round_q;
    assign step_o  = step_q;

endmodule

// File: rtl/blake_round_ctrl.sv
// BLAKE-512 compression sequencer: block intake, bit counter t, v-load, 64 round steps, digest handshake.
module blake_round_ctrl
    import blake_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic               blk_last,
    input  logic [BITS_W-1:0]  blk_bits,
    output logic               init_round,
    output logic               load_v,
    output logic               round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic [STEP_W-1:0]  step_idx,
    output logic               count_done,
    output logic [T_W-1:0]     t_out,
    output logic               hash_valid,
    input  logic               hash_ready,
    output logic               busy
);

    state_e             state_q, state_d;
    logic               first_q, first_d;
    logic               last_q,  last_d;
    logic [T_W-1:0]     t_q,     t_d;
    logic [T_W-1:0]     t_out_q, t_out_d;

    logic [BITS_W-1:0]  bits_sat;
    logic [T_W-1:0]     t_new;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;

    // Counter restarts with every message; otherwise accumulate modulo 2^T_W.
    assign bits_sat = sat_bits(blk_bits);
    assign t_new    = first_q ? T_W'(bits_sat) : t_q + T_W'(bits_sat);

    blake_round_cnt u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .round_o (round_idx),
        .step_o  (step_idx),
        .tc_o    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            t_q     <= '0;
            t_out_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            t_q     <= t_d;
            t_out_q <= t_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        last_d     = last_q;
        t_d        = t_q;
        t_out_d    = t_out_q;
        blk_ready  = 1'b0;
        init_round = 1'b0;
        load_v     = 1'b0;
        round_en   = 1'b0;
        count_done = 1'b0;
        hash_valid = 1'b0;
        cnt_clr    = 1'b1;
        cnt_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    last_d     = blk_last;
                    t_d        = t_new;
                    // A padding-only block hashes with t=0 but leaves the running count intact.
                    t_out_d    = (bits_sat == '0) ? '0 : t_new;
                    init_round = first_q;
                    first_d    = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_v  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                round_en = 1'b1;
                cnt_clr  = 1'b0;
                cnt_en   = 1'b1;
                if (cnt_tc) begin
                    count_done = 1'b1;
                    state_d    = last_q ? ST_OUT : ST_IDLE;
                end
            end
            ST_OUT: begin
                hash_valid = 1'b1;
                if (hash_ready) begin
                    first_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign t_out = t_out_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed bench for blake_round_ctrl with a cycle-timeline reference model and literal spot checks.
module tb_blake_round_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic         blk_last = 1'b0;
    logic [10:0]  blk_bits = '0;
    logic         init_round;
    logic         load_v;
    logic         round_en;
    logic [3:0]   round_idx;
    logic [1:0]   step_idx;
    logic         count_done;
    logic [127:0] t_out;
    logic         hash_valid;
    logic         hash_ready = 1'b0;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    blake_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_last   (blk_last),
        .blk_bits   (blk_bits),
        .init_round (init_round),
        .load_v     (load_v),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .step_idx   (step_idx),
        .count_done (count_done),
        .t_out      (t_out),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the 66-cycle compression timeline plus digest-pending flag.
    int           m_k     = -1;
    bit           m_pend  = 1'b0;
    bit           m_first = 1'b1;
    bit           m_last  = 1'b0;
    logic [127:0] m_t     = '0;
    logic [127:0] m_tout  = '0;
    logic [127:0] m_tnew;
    int           m_b;
    bit           m_idle;

    always @(negedge clk) begin
        if (chk_en) begin
            m_idle = (m_k < 0) && !m_pend;
            chk("m_blk_ready",  128'(blk_ready),  128'(m_idle));
            chk("m_busy",       128'(busy),       128'(!m_idle));
            chk("m_init_round", 128'(init_round), 128'(m_idle && blk_valid && m_first));
            chk("m_load_v",     128'(load_v),     128'(m_k == 1));
            chk("m_round_en",   128'(round_en),   128'(m_k >= 2));
            chk("m_round_idx",  128'(round_idx),  128'((m_k >= 2) ? (m_k - 2) / 4 : 0));
            chk("m_step_idx",   128'(step_idx),   128'((m_k >= 2) ? (m_k - 2) % 4 : 0));
            chk("m_count_done", 128'(count_done), 128'(m_k == 65));
            chk("m_hash_valid", 128'(hash_valid), 128'(m_pend));
            chk("m_t_out",      t_out,            m_tout);

            if (rst) begin
                m_k = -1; m_pend = 1'b0; m_first = 1'b1; m_last = 1'b0;
                m_t = '0; m_tout = '0;
            end else if (m_idle && blk_valid) begin
                m_b     = (int'(blk_bits) > 1024) ? 1024 : int'(blk_bits);
                m_tnew  = m_first ? 128'(m_b) : m_t + 128'(m_b);
                m_t     = m_tnew;
                m_tout  = (m_b == 0) ? '0 : m_tnew;
                m_first = 1'b0;
                m_last  = blk_last;
                m_k     = 1;
            end else if (m_k >= 1 && m_k < 65) begin
                m_k++;
            end else if (m_k == 65) begin
                m_k    = -1;
                m_pend = m_last;
            end else if (m_pend && hash_ready) begin
                m_pend  = 1'b0;
                m_first = 1'b1;
            end
        end
    end

    // Present a block for one cycle while idle; leaves the bench at cycle 1 (LOAD).
    task automatic accept(input logic [10:0] bits, input bit last, input bit exp_init);
        blk_valid = 1'b1;
        blk_bits  = bits;
        blk_last  = last;
        @(negedge clk);
        chk("acc_blk_ready", 128'(blk_ready), 128'(1));
        chk("acc_init_round", 128'(init_round), 128'(exp_init));
        @(posedge clk); #1;
        blk_valid = 1'b0;
        blk_bits  = 11'h5A5;
        blk_last  = 1'b0;
        chk("acc_load_v", 128'(load_v), 128'(1));
    endtask

    // Run out the compression and, for the last block, take the digest after `hold` stalled cycles.
    task automatic finish_block(input bit last, input logic [127:0] exp_tout, input int hold);
        int n = 0;
        int re_cnt = 0;
        chk("fin_t_out_load", t_out, exp_tout);
        while (!count_done && n < 100) begin
            re_cnt += int'(round_en);
            @(posedge clk); #1;
            n++;
        end
        re_cnt += int'(round_en);
        chk("fin_count_done_cycle", 128'(n + 1), 128'(65));
        chk("fin_round_en_count", 128'(re_cnt), 128'(64));
        chk("fin_round_idx", 128'(round_idx), 128'(15));
        chk("fin_step_idx", 128'(step_idx), 128'(3));
        chk("fin_t_out_done", t_out, exp_tout);
        @(posedge clk); #1;
        if (last) begin
            chk("fin_hash_valid", 128'(hash_valid), 128'(1));
            blk_valid = (hold > 0);
            blk_bits  = 11'd5;
            for (int i = 0; i < hold; i++) begin
                chk("hold_hash_valid", 128'(hash_valid), 128'(1));
                chk("hold_blk_ready", 128'(blk_ready), 128'(0));
                @(posedge clk); #1;
            end
            blk_valid  = 1'b0;
            hash_ready = 1'b1;
            @(posedge clk); #1;
            hash_ready = 1'b0;
            chk("fin_hash_taken", 128'(hash_valid), 128'(0));
            chk("fin_ready_after_hash", 128'(blk_ready), 128'(1));
        end else begin
            chk("fin_hash_valid_nonlast", 128'(hash_valid), 128'(0));
            chk("fin_ready_nonlast", 128'(blk_ready), 128'(1));
        end
    endtask

    initial begin
        int n;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_blk_ready", 128'(blk_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_hash_valid", 128'(hash_valid), 128'(0));
        chk("rst_t_out", t_out, 128'h0);

        // Single full final block.
        accept(11'd1024, 1'b1, 1'b1);
        finish_block(1'b1, 128'h400, 0);

        // Two blocks, 1024 then 1000.
        accept(11'd1024, 1'b0, 1'b1);
        finish_block(1'b0, 128'h400, 0);
        accept(11'd1000, 1'b1, 1'b0);
        finish_block(1'b1, 128'h7E8, 0);

        // Padding-only final block.
        accept(11'd1024, 1'b0, 1'b1);
        finish_block(1'b0, 128'h400, 0);
        accept(11'd0, 1'b1, 1'b0);
        finish_block(1'b1, 128'h0, 0);

        // Padding-only middle block must not disturb the running count.
        accept(11'd1024, 1'b0, 1'b1);
        finish_block(1'b0, 128'h400, 0);
        accept(11'd0, 1'b0, 1'b0);
        finish_block(1'b0, 128'h0, 0);
        accept(11'd1000, 1'b1, 1'b0);
        finish_block(1'b1, 128'h7E8, 0);

        // Digest stalled 10 cycles with blk_valid pushing; next message restarts t.
        accept(11'd512, 1'b1, 1'b1);
        finish_block(1'b1, 128'h200, 10);
        accept(11'd300, 1'b1, 1'b1);
        finish_block(1'b1, 128'h12C, 0);

        // Reset in round 7.
        accept(11'd1024, 1'b0, 1'b1);
        n = 0;
        while (round_idx != 4'd7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_wait_round7", 128'(round_idx), 128'(7));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_blk_ready", 128'(blk_ready), 128'(1));
        chk("midrst_count_done", 128'(count_done), 128'(0));
        chk("midrst_round_idx", 128'(round_idx), 128'(0));
        accept(11'd200, 1'b1, 1'b1);
        finish_block(1'b1, 128'hC8, 0);

        // Oversized bit count saturates.
        accept(11'd2047, 1'b1, 1'b1);
        finish_block(1'b1, 128'h400, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
